// File: rtl/and_chain_deserializer_pkg.sv
// Shared types and width helpers for the And2 reduction chain receive side.
// Imported by the deserializer top and its beat counter.
package and_chain_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Count width for an arbitrary word width; keeps at least one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/and_chain_deserializer_if.sv
// Serial-in / word-out handshake bundle for the And2 chain deserializer.
// slave is the deserializer side, master is the link/downstream side.
interface and_chain_deserializer_if #(
    parameter int WIDTH = 4
) ();

    logic             I;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O;
    logic             O_all;
    logic             O_valid;
    logic             O_ready;

    modport slave (
        input  I, I_valid, O_ready,
        output I_ready, O, O_all, O_valid
    );

    modport master (
        output I, I_valid, O_ready,
        input  I_ready, O, O_all, O_valid
    );

endinterface

// File: rtl/and_chain_deserializer_beat_counter.sv
// Modulo-WIDTH beat counter with enable, async clear and a last-beat flag.
// Wraps to zero only when the last beat of a word is counted.
module and_chain_beat_counter
    import and_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CW   = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/and_chain_deserializer.sv
// Bit-serial receiver: collects WIDTH beats into a word with its running AND and
// presents it on a valid/ready output; a second word may be collected while O waits.
module and_chain_deserializer
    import and_chain_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESET,
    and_chain_deserializer_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_n;
    logic [CW-1:0]    count;
    logic             last;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] col, word_next, o_q;
    logic             acc, o_all_q, o_valid_q;
    logic             i_ready, accept, drain;
    logic             load_new, load_pend, clr_valid;

    assign i_ready     = (state == COLLECT);
    assign accept      = bus.I_valid & i_ready;
    assign drain       = o_valid_q & bus.O_ready;

    assign bus.I_ready = i_ready;
    assign bus.O       = o_q;
    assign bus.O_all   = o_all_q;
    assign bus.O_valid = o_valid_q;

    and_chain_beat_counter #(.WIDTH(WIDTH)) u_beat_counter (
        .clk   (CLK),
        .rst   (ASYNCRESET),
        .en    (accept),
        .count (count),
        .last  (last)
    );

    assign pos = LSB_FIRST ? count : CW'(WIDTH - 1) - count;

    // Collect register with the current beat already merged in.
    always_comb begin
        word_next      = col;
        word_next[pos] = bus.I;
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        load_new  = 1'b0;
        load_pend = 1'b0;
        clr_valid = 1'b0;
        case (state)
            COLLECT: begin
                if (accept && last) begin
                    if (!o_valid_q || drain) begin
                        load_new = 1'b1;
                    end else begin
                        state_n = STALL;
                    end
                end else if (drain) begin
                    clr_valid = 1'b1;
                end
            end
            STALL: begin
                if (drain) begin
                    load_pend = 1'b1;
                    state_n   = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // While stalled, col and acc hold the complete pending word and its AND.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            col       <= '0;
            acc       <= 1'b1;
            o_q       <= '0;
            o_all_q   <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                col <= word_next;
            end
            if (load_new || load_pend) begin
                acc <= 1'b1;
            end else if (accept) begin
                acc <= acc & bus.I;
            end
            if (load_new) begin
                o_q       <= word_next;
                o_all_q   <= acc & bus.I;
                o_valid_q <= 1'b1;
            end else if (load_pend) begin
                o_q       <= col;
                o_all_q   <= acc;
                o_valid_q <= 1'b1;
            end else if (clr_valid) begin
                o_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_and_chain_deserializer.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared each cycle against a queue-of-words model plus directed literal checks.
module tb_and_chain_deserializer;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    and_chain_deserializer_if #(.WIDTH(W)) bus_l ();
    and_chain_deserializer_if #(.WIDTH(W)) bus_m ();

    and_chain_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .CLK        (clk),
        .ASYNCRESET (rst),
        .bus        (bus_l)
    );

    and_chain_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .CLK        (clk),
        .ASYNCRESET (rst),
        .bus        (bus_m)
    );

    int tests = 0;
    int fails = 0;

    // Model: words completed but not yet taken, in LSB-first bit order.
    logic [W-1:0] q[$];
    logic [W-1:0] pw = '0;
    int           pcnt = 0;
    int           words_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic check_model();
        chk("o_valid_l", 32'(bus_l.O_valid), 32'(q.size() > 0));
        chk("i_ready_l", 32'(bus_l.I_ready), 32'(q.size() < 2));
        chk("o_valid_m", 32'(bus_m.O_valid), 32'(q.size() > 0));
        chk("i_ready_m", 32'(bus_m.I_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("o_word_l", 32'(bus_l.O), 32'(q[0]));
            chk("o_all_l", 32'(bus_l.O_all), 32'(q[0] == '1));
            chk("o_word_m", 32'(bus_m.O), 32'(rev(q[0])));
            chk("o_all_m", 32'(bus_m.O_all), 32'(q[0] == '1));
        end
        if (bus_l.O_valid) chk("inv_all_l", 32'(bus_l.O_all), 32'(&bus_l.O));
        if (bus_m.O_valid) chk("inv_all_m", 32'(bus_m.O_all), 32'(&bus_m.O));
    endtask

    task automatic drive(input bit iv, input bit ib, input bit ordy);
        bus_l.I_valid = iv;  bus_l.I = ib;  bus_l.O_ready = ordy;
        bus_m.I_valid = iv;  bus_m.I = ib;  bus_m.O_ready = ordy;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic cycle(input bit iv, input bit ib, input bit ordy);
        bit acc_b, drn_b;
        drive(iv, ib, ordy);
        drn_b = ordy && (q.size() > 0);
        acc_b = iv && (q.size() < 2);
        if (drn_b) begin
            void'(q.pop_front());
            words_out++;
        end
        if (acc_b) begin
            pw[pcnt] = ib;
            pcnt++;
            if (pcnt == W) begin
                q.push_back(pw);
                pcnt = 0;
                pw   = '0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit ordy);
        for (int b = 0; b < W; b++) cycle(1'b1, w[b], ordy);
    endtask

    initial begin
        int base;
        int cyc;
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_o", 32'(bus_l.O), 0);
        chk("rst_o_all", 32'(bus_l.O_all), 0);
        chk("rst_o_valid", 32'(bus_l.O_valid), 0);
        chk("rst_i_ready", 32'(bus_l.I_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        check_model();

        // 1: all ones, O_valid one cycle after the last beat
        for (int b = 0; b < W - 1; b++) cycle(1'b1, 1'b1, 1'b1);
        chk("t1_no_early_valid", 32'(bus_l.O_valid), 0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("t1_word", 32'(bus_l.O), 32'h0000000F);
        chk("t1_all", 32'(bus_l.O_all), 1);
        chk("t1_valid", 32'(bus_l.O_valid), 1);

        // 2: 1,0,1,1 in both bit orders
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t2_word_lsb", 32'(bus_l.O), 32'h0000000D);
        chk("t2_word_msb", 32'(bus_m.O), 32'h0000000B);
        chk("t2_all", 32'(bus_l.O_all), 0);
        cycle(1'b0, 1'b0, 1'b1);

        // 3: two words under back-pressure, then released in order
        send_word(4'hA, 1'b0);
        send_word(4'h3, 1'b0);
        chk("t3_stall_ready", 32'(bus_l.I_ready), 0);
        chk("t3_first_held", 32'(bus_l.O), 32'h0000000A);
        cycle(1'b0, 1'b0, 1'b1);
        chk("t3_second", 32'(bus_l.O), 32'h00000003);
        chk("t3_second_valid", 32'(bus_l.O_valid), 1);
        chk("t3_ready_back", 32'(bus_l.I_ready), 1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("t3_empty", 32'(bus_l.O_valid), 0);

        // 4: drain coincides with each last beat -> no bubble
        for (int w = 0; w < 3; w++) begin
            logic [W-1:0] wv;
            wv = W'(5 + w);
            for (int b = 0; b < W; b++) begin
                cycle(1'b1, wv[b], (b == W - 1) && (w > 0));
                if (w > 0 || b == W - 1) chk("t4_no_gap", 32'(bus_l.O_valid), 1);
            end
        end
        chk("t4_last_word", 32'(bus_l.O), 32'h00000007);
        cycle(1'b0, 1'b0, 1'b1);

        // 5: async reset between edges discards held and partial words
        send_word(4'hF, 1'b0);
        for (int b = 0; b < 3; b++) cycle(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5_o", 32'(bus_l.O), 0);
        chk("t5_o_all", 32'(bus_l.O_all), 0);
        chk("t5_o_valid", 32'(bus_l.O_valid), 0);
        chk("t5_i_ready", 32'(bus_l.I_ready), 1);
        chk("t5_o_m", 32'(bus_m.O), 0);
        q.delete();
        pcnt = 0;
        pw   = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(4'hF, 1'b0);
        chk("t5_word_after", 32'(bus_l.O), 32'h0000000F);
        chk("t5_all_after", 32'(bus_l.O_all), 1);
        cycle(1'b0, 1'b0, 1'b1);

        // 6: random gaps on both sides
        base = words_out;
        cyc  = 0;
        while ((words_out - base) < 1000 && cyc < 30000) begin
            cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 60);
            cyc++;
        end
        chk("t6_words", 32'(words_out - base), 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
